// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - program memory feeder that issues instructions to the core
// Loads a small program while idle, then issues each word in order using the core's start/busy handshake.
module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PROGRAM_DEPTH     = 16,
    parameter int ADDR_WIDTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         loadEnable,
    input  logic [ADDR_WIDTH-1:0]        loadAddress,
    input  logic [INSTRUCTION_WIDTH-1:0] loadData,
    input  logic [ADDR_WIDTH:0]          programLength,
    input  logic                         run,
    input  logic                         coreBusy,
    output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
    output logic                         start,
    output logic [ADDR_WIDTH:0]          programCounter,
    output logic                         running,
    output logic                         done,
    output logic                         loadRejected
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(PROGRAM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLDOFF,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH:0]            pc_q, pc_d;
    logic [ADDR_WIDTH:0]            len_q, len_d;
    logic [ADDR_WIDTH:0]            run_len;
    logic                           rejected_q, rejected_d;
    logic                           load_ok_state;
    logic                           addr_in_range;
    logic                           mem_we;
    logic [INSTRUCTION_WIDTH-1:0]   rd_word;
    logic [INSTRUCTION_WIDTH-1:0]   mem_q [PROGRAM_DEPTH];

    assign load_ok_state = (state_q == S_IDLE) || (state_q == S_DONE);
    assign addr_in_range = {1'b0, loadAddress} < DEPTH_C;
    assign mem_we        = loadEnable && load_ok_state && addr_in_range;
    assign rejected_d    = loadEnable && !mem_we;
    assign run_len       = (programLength > DEPTH_C) ? DEPTH_C : programLength;

    // Program memory is deliberately left out of reset so a reset mid-run keeps the program.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PROGRAM_DEPTH; i++) begin
            if (mem_we && (loadAddress == ADDR_WIDTH'(i))) begin
                mem_q[i] <= loadData;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < PROGRAM_DEPTH; i++) begin
            if (pc_q == (ADDR_WIDTH+1)'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            rejected_q <= rejected_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (run) begin
                    len_d   = run_len;
                    pc_d    = '0;
                    state_d = (run_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!coreBusy) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_HOLDOFF;
                end
            end
            // One dead cycle so the core can raise busy before we look at it.
            S_HOLDOFF: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!coreBusy) begin
                    state_d = (pc_q < len_q) ? S_ISSUE : S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start          = 1'b0;
        running        = 1'b0;
        done           = 1'b0;
        instructionOut = '0;
        case (state_q)
            S_ISSUE: begin
                start          = 1'b1;
                running        = 1'b1;
                instructionOut = rd_word;
            end
            S_HOLDOFF, S_WAIT: begin
                running = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                start = 1'b0;
            end
        endcase
    end

    assign programCounter = pc_q;
    assign loadRejected   = rejected_q;

endmodule
